fp_normalizer: RTL and testbench



---
 rtl/fp_pkg.sv | 47 ++++
 rtl/fp_lshift_step.sv | 12 +
 rtl/fp_normalizer.sv | 110 +++++++++++
 tb/tb_fp_normalizer.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared constants, FSM states and the shift-planning rule for the FP normalizer.
package fp_pkg;

  localparam int unsigned MW   = 28;
  localparam int unsigned EW   = 8;
  localparam int unsigned STEP = 8;
  localparam int unsigned ZW   = $clog2(MW + 1);
  localparam int unsigned SAW  = $clog2(STEP + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef struct packed {
    logic [ZW-1:0] s;
    logic [EW-1:0] exp_out;
    logic          uflow;
    logic          zero;
  } shift_plan_t;

  // Shift amount and result exponent from the leading-zero count and biased exponent.
  // When the count would push the exponent below 1, shift only down to the denormal floor.
  function automatic shift_plan_t plan_shift(input logic [ZW-1:0] z, input logic [EW-1:0] e);
    int unsigned zi;
    int unsigned ei;
    shift_plan_t p;
    zi        = 32'(z);
    ei        = 32'(e);
    p.s       = '0;
    p.exp_out = '0;
    p.uflow   = 1'b0;
    p.zero    = 1'b0;
    if (zi >= MW) begin
      p.zero = 1'b1;
    end else if (zi < ei) begin
      p.s       = z;
      p.exp_out = EW'(ei - zi);
    end else begin
      p.s     = (ei == 0) ? '0 : ZW'(ei - 1);
      p.uflow = 1'b1;
    end
    return p;
  endfunction

endpackage

// File: rtl/fp_lshift_step.sv
// One step of the iterative normalizer: left shift by 0..STEP bits, zero filled.
module fp_lshift_step
  import fp_pkg::*;
(
  input  logic [MW-1:0]  din,
  input  logic [SAW-1:0] amt,
  output logic [MW-1:0]  dout
);

  assign dout = din << amt;

endmodule

// File: rtl/fp_normalizer.sv
// Iterative mantissa normalizer between the leading-zero counter and the rounding stage.
//   state | meaning
//   IDLE  | waiting for an operand, in_ready high
//   SHIFT | shifting mantissa up to STEP bits per cycle
//   DONE  | result presented, held until out_ready
module fp_normalizer
  import fp_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_sign,
  input  logic [MW-1:0] in_mant,
  input  logic [EW-1:0] in_exp,
  input  logic [ZW-1:0] in_zcount,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_sign,
  output logic [MW-1:0] out_mant,
  output logic [EW-1:0] out_exp,
  output logic          out_zero,
  output logic          out_uflow
);

  localparam logic [ZW-1:0] STEP_Z = ZW'(STEP);

  state_t        state_q, state_d;
  logic [MW-1:0] mant_q, mant_d;
  logic [EW-1:0] exp_q, exp_d;
  logic [ZW-1:0] rem_q, rem_d;
  logic          sign_q, sign_d;
  logic          zero_q, zero_d;
  logic          uflow_q, uflow_d;

  shift_plan_t   plan;
  logic [SAW-1:0] step_amt;
  logic [MW-1:0]  mant_shifted;

  always_comb plan = plan_shift(in_zcount, in_exp);

  always_comb step_amt = (rem_q > STEP_Z) ? SAW'(STEP) : SAW'(rem_q);

  fp_lshift_step u_step (
    .din  (mant_q),
    .amt  (step_amt),
    .dout (mant_shifted)
  );

  always_comb begin
    state_d = state_q;
    mant_d  = mant_q;
    exp_d   = exp_q;
    rem_d   = rem_q;
    sign_d  = sign_q;
    zero_d  = zero_q;
    uflow_d = uflow_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d  = in_sign;
          mant_d  = plan.zero ? '0 : in_mant;
          exp_d   = plan.exp_out;
          zero_d  = plan.zero;
          uflow_d = plan.uflow;
          rem_d   = plan.s;
          state_d = (plan.s == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        mant_d = mant_shifted;
        rem_d  = rem_q - ZW'(step_amt);
        if (rem_q <= STEP_Z) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mant_q  <= '0;
      exp_q   <= '0;
      rem_q   <= '0;
      sign_q  <= 1'b0;
      zero_q  <= 1'b0;
      uflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mant_q  <= mant_d;
      exp_q   <= exp_d;
      rem_q   <= rem_d;
      sign_q  <= sign_d;
      zero_q  <= zero_d;
      uflow_q <= uflow_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_sign  = sign_q;
  assign out_mant  = mant_q;
  assign out_exp   = exp_q;
  assign out_zero  = zero_q;
  assign out_uflow = uflow_q;

endmodule

// File: tb/tb_fp_normalizer.sv
// Self-checking bench for fp_normalizer: directed table, reset/backpressure sequences, random ops.
module tb_fp_normalizer;
  import fp_pkg::*;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          in_sign = 1'b0;
  logic [MW-1:0] in_mant = '0;
  logic [EW-1:0] in_exp = '0;
  logic [ZW-1:0] in_zcount = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          out_sign;
  logic [MW-1:0] out_mant;
  logic [EW-1:0] out_exp;
  logic          out_zero;
  logic          out_uflow;

  int total = 0;
  int bad   = 0;

  fp_normalizer dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_sign(in_sign),
    .in_mant(in_mant), .in_exp(in_exp), .in_zcount(in_zcount),
    .out_valid(out_valid), .out_ready(out_ready), .out_sign(out_sign),
    .out_mant(out_mant), .out_exp(out_exp), .out_zero(out_zero), .out_uflow(out_uflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          sign;
    logic [MW-1:0] mant;
    logic [EW-1:0] exp;
    logic [ZW-1:0] z;
    logic [MW-1:0] x_mant;
    logic [EW-1:0] x_exp;
    logic          x_zero;
    logic          x_uflow;
    int            x_lat;
    int            hold;
  } vec_t;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: arithmetic restatement of the normalization rules.
  task automatic ref_model(input logic [MW-1:0] mant, input logic [EW-1:0] e,
                           input logic [ZW-1:0] z, output vec_t r);
    int s;
    int zi;
    int ei;
    longint m;
    zi = int'(z);
    ei = int'(e);
    s = 0;
    r.x_zero = 0; r.x_uflow = 0; r.x_exp = 0; r.x_mant = 0;
    if (zi >= int'(MW)) begin
      r.x_zero = 1;
    end else begin
      if (zi < ei) begin
        s = zi;
        r.x_exp = EW'(ei - zi);
      end else begin
        s = (ei == 0) ? 0 : ei - 1;
        r.x_uflow = 1;
      end
      m = longint'(mant) * (longint'(1) << s);
      r.x_mant = MW'(m % (longint'(1) << MW));
    end
    r.x_lat = (s + int'(STEP) - 1) / int'(STEP);
  endtask

  task automatic check_idle_reset(input string tag);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_mant"}, out_mant, 0);
    check({tag, "_out_exp"}, out_exp, 0);
    check({tag, "_out_sign"}, out_sign, 0);
    check({tag, "_out_zero"}, out_zero, 0);
    check({tag, "_out_uflow"}, out_uflow, 0);
  endtask

  task automatic check_outputs(input vec_t v, input string tag);
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_mant"}, out_mant, v.x_mant);
    check({tag, "_exp"}, out_exp, v.x_exp);
    check({tag, "_sign"}, out_sign, v.sign);
    check({tag, "_zero"}, out_zero, v.x_zero);
    check({tag, "_uflow"}, out_uflow, v.x_uflow);
  endtask

  // Called one #1 after a posedge with the DUT in IDLE.
  task automatic run_op(input vec_t v, input bit noisy, input string tag);
    int lat;
    check({tag, "_ready_before"}, in_ready, 1);
    in_sign = v.sign; in_mant = v.mant; in_exp = v.exp; in_zcount = v.z;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
    if (noisy) begin
      in_mant = MW'($urandom); in_exp = EW'($urandom); in_zcount = ZW'($urandom); in_sign = ~v.sign;
    end
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (noisy) in_valid = 1'($urandom_range(0, 1));
    end
    check({tag, "_latency"}, lat, v.x_lat);
    check_outputs(v, tag);
    for (int i = 0; i < v.hold; i++) begin
      @(posedge clk); #1;
      check_outputs(v, {tag, "_hold"});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_release_valid"}, out_valid, 0);
    check({tag, "_release_ready"}, in_ready, 1);
  endtask

  function automatic int clz(input logic [MW-1:0] m);
    for (int i = int'(MW) - 1; i >= 0; i--) if (m[i]) return int'(MW) - 1 - i;
    return int'(MW);
  endfunction

  vec_t tbl[8];
  vec_t v;
  vec_t r;

  initial begin
    tbl[0] = '{0, 28'h0000123, 8'd100, 5'd15, 28'h0918000, 8'd85, 0, 0, 2, 0};
    tbl[1] = '{0, 28'h8000000, 8'd10,  5'd0,  28'h8000000, 8'd10, 0, 0, 0, 10};
    tbl[2] = '{1, 28'h0000000, 8'd77,  5'd28, 28'h0000000, 8'd0,  1, 0, 0, 0};
    tbl[3] = '{1, 28'h0000000, 8'd77,  5'd31, 28'h0000000, 8'd0,  1, 0, 0, 0};
    tbl[4] = '{0, 28'h0000400, 8'd5,   5'd17, 28'h0004000, 8'd0,  0, 1, 1, 0};
    tbl[5] = '{1, 28'h0000400, 8'd0,   5'd17, 28'h0000400, 8'd0,  0, 1, 0, 0};
    tbl[6] = '{0, 28'h0000001, 8'd200, 5'd27, 28'h8000000, 8'd173, 0, 0, 4, 0};
    tbl[7] = '{1, 28'h0000001, 8'd27,  5'd27, 28'h4000000, 8'd0,  0, 1, 4, 3};

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_idle_reset("reset");

    foreach (tbl[i]) run_op(tbl[i], 1'b0, $sformatf("vec%0d", i));

    // Reset during the second SHIFT cycle of a 4-cycle shift.
    in_sign = 1; in_mant = 28'h0000001; in_exp = 8'd200; in_zcount = 5'd27; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_idle_reset("midshift_rst");
    @(posedge clk); #1;
    check({"midshift_no_result"}, out_valid, 0);
    run_op(tbl[0], 1'b0, "after_rst");

    for (int n = 0; n < 200; n++) begin
      v.sign = 1'($urandom_range(0, 1));
      v.mant = MW'($urandom);
      if ($urandom_range(0, 3) == 0) v.mant = v.mant >> $urandom_range(0, 28);
      v.exp = ($urandom_range(0, 1) == 1) ? EW'($urandom_range(0, 40)) : EW'($urandom);
      v.z = ($urandom_range(0, 3) == 0) ? ZW'($urandom) : ZW'(clz(v.mant));
      v.hold = $urandom_range(0, 3);
      ref_model(v.mant, v.exp, v.z, r);
      v.x_mant = r.x_mant; v.x_exp = r.x_exp; v.x_zero = r.x_zero;
      v.x_uflow = r.x_uflow; v.x_lat = r.x_lat;
      run_op(v, 1'b1, $sformatf("rnd%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
